// File: rtl/debug_bridge.sv
// Debug bridge: parses ASCII commands from a UART byte stream and turns them into
// memory-port bursts, CPU hold/release, and single-byte ACK/NAK replies.
module debug_bridge #(
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4,
  parameter int MAX_BURST  = 16,
  parameter int TIMEOUT    = 100000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_valid,
  output logic [7:0]              tx_byte,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [8*ADDR_BYTES-1:0] mem_addr,
  output logic [8*DATA_BYTES-1:0] mem_wdata,
  output logic                    mem_we,
  output logic                    mem_req,
  input  logic                    mem_ack,
  input  logic [8*DATA_BYTES-1:0] mem_rdata,
  output logic                    cpu_reset_req,
  output logic [7:0]              err_count
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT);
  localparam logic [7:0]    ADDR_LAST = 8'(ADDR_BYTES - 1);
  localparam logic [7:0]    DATA_LAST = 8'(DATA_BYTES - 1);
  localparam logic [7:0]    BURST_MAX = 8'(MAX_BURST);
  localparam logic [AW-1:0] ADDR_STEP = AW'(DATA_BYTES);

  localparam logic [7:0] CH_P = 8'h50;
  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_G = 8'h47;
  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_N = 8'h4E;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_LEN, GET_DATA, MEM_WR, MEM_RD, SEND_DATA, SEND_RESP
  } state_t;

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [7:0]    cnt_q;
  logic [7:0]    byte_q;
  logic [7:0]    resp_q;
  logic [7:0]    tx_byte_q;
  logic [7:0]    err_q;
  logic [TW-1:0] tmr_q;
  logic          is_wr_q;
  logic          tx_start_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic          cpu_rst_q;

  logic tx_ready;
  logic tmr_expired;

  // A start is never issued back-to-back, so busy has a cycle to rise after each one.
  assign tx_ready    = !tx_busy && !tx_start_q;
  assign tmr_expired = !rx_valid && (tmr_q <= TW'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      byte_q     <= '0;
      resp_q     <= '0;
      tx_byte_q  <= '0;
      err_q      <= '0;
      tmr_q      <= '0;
      is_wr_q    <= 1'b0;
      tx_start_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_rst_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            byte_q <= '0;
            tmr_q  <= TMR_LOAD;
            case (rx_byte)
              CH_P: begin resp_q <= CH_A; state_q <= SEND_RESP; end
              CH_H: begin resp_q <= CH_A; cpu_rst_q <= 1'b1; state_q <= SEND_RESP; end
              CH_G: begin resp_q <= CH_A; cpu_rst_q <= 1'b0; state_q <= SEND_RESP; end
              CH_W, CH_R: begin
                is_wr_q <= (rx_byte == CH_W);
                addr_q  <= '0;
                state_q <= GET_ADDR;
              end
              default: begin resp_q <= CH_N; state_q <= SEND_RESP; end
            endcase
          end
        end
        GET_ADDR: begin
          if (rx_valid) begin
            addr_q <= (addr_q << 8) | AW'(rx_byte);
            tmr_q  <= TMR_LOAD;
            if (byte_q == ADDR_LAST) begin
              byte_q  <= '0;
              state_q <= GET_LEN;
            end else begin
              byte_q <= byte_q + 8'd1;
            end
          end else if (tmr_expired) begin
            resp_q  <= CH_N;
            state_q <= SEND_RESP;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        GET_LEN: begin
          if (rx_valid) begin
            tmr_q <= TMR_LOAD;
            cnt_q <= rx_byte;
            if (rx_byte == 8'd0 || rx_byte > BURST_MAX) begin
              resp_q  <= CH_N;
              state_q <= SEND_RESP;
            end else if (is_wr_q) begin
              state_q <= GET_DATA;
            end else begin
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
              state_q   <= MEM_RD;
            end
          end else if (tmr_expired) begin
            resp_q  <= CH_N;
            state_q <= SEND_RESP;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        GET_DATA: begin
          if (rx_valid) begin
            data_q <= (data_q << 8) | DW'(rx_byte);
            tmr_q  <= TMR_LOAD;
            if (byte_q == DATA_LAST) begin
              byte_q    <= '0;
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b1;
              state_q   <= MEM_WR;
            end else begin
              byte_q <= byte_q + 8'd1;
            end
          end else if (tmr_expired) begin
            resp_q  <= CH_N;
            state_q <= SEND_RESP;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        MEM_WR: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= addr_q + ADDR_STEP;
            cnt_q     <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              resp_q  <= CH_A;
              state_q <= SEND_RESP;
            end else begin
              tmr_q   <= TMR_LOAD;
              state_q <= GET_DATA;
            end
          end
        end
        MEM_RD: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            data_q    <= mem_rdata;
            byte_q    <= '0;
            state_q   <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          if (tx_ready) begin
            tx_start_q <= 1'b1;
            tx_byte_q  <= data_q[DW-1 -: 8];
            data_q     <= data_q << 8;
            if (byte_q == DATA_LAST) begin
              byte_q <= '0;
              addr_q <= addr_q + ADDR_STEP;
              cnt_q  <= cnt_q - 8'd1;
              if (cnt_q == 8'd1) begin
                state_q <= IDLE;
              end else begin
                mem_req_q <= 1'b1;
                mem_we_q  <= 1'b0;
                state_q   <= MEM_RD;
              end
            end else begin
              byte_q <= byte_q + 8'd1;
            end
          end
        end
        SEND_RESP: begin
          if (tx_ready) begin
            tx_start_q <= 1'b1;
            tx_byte_q  <= resp_q;
            if (resp_q == CH_N && err_q != 8'hFF) err_q <= err_q + 8'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_byte       = tx_byte_q;
  assign tx_start      = tx_start_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = data_q;
  assign mem_we        = mem_we_q;
  assign mem_req       = mem_req_q;
  assign cpu_reset_req = cpu_rst_q;
  assign err_count     = err_q;

endmodule

// File: doc/debug_bridge.md
DEBUG_BRIDGE -- requirements
Module: debug_bridge

Interface
REQ-001 Parameter ADDR_BYTES, default 4, address bytes per command; address width AW = 8*ADDR_BYTES.
REQ-002 Parameter DATA_BYTES, default 4, bytes per memory word; data width DW = 8*DATA_BYTES.
REQ-003 Parameter MAX_BURST, default 16, maximum words per burst command (1..255).
REQ-004 Parameter TIMEOUT, default 100000, idle cycles allowed between received bytes of one command.
REQ-005 CLK  in  1  clock; all logic on posedge CLK; one clock only.
REQ-006 RST  in  1  synchronous, active-high reset.
REQ-007 rx_byte  in  8  received byte from UART.
REQ-008 rx_valid  in  1  one-cycle strobe, rx_byte valid.
REQ-009 tx_byte  out  8  byte to transmit.
REQ-010 tx_start  out  1  one-cycle request to send tx_byte.
REQ-011 tx_busy  in  1  UART transmitter busy; goes high the cycle after an accepted tx_start.
REQ-012 mem_addr  out  AW  word address.
REQ-013 mem_wdata  out  DW  write data.
REQ-014 mem_we  out  1  write qualifier for the current request.
REQ-015 mem_req  out  1  request valid; held until mem_ack.
REQ-016 mem_ack  in  1  request complete; mem_rdata valid in the same cycle on reads.
REQ-017 mem_rdata  in  DW  read data.
REQ-018 cpu_reset_req  out  1  holds CPU in reset while high.
REQ-019 err_count  out  8  saturating count of NAKed commands.

Function
REQ-020 Commands are ASCII, multi-byte fields MSB first: 'P' ping; 'H' halt, sets cpu_reset_req; 'G' go, clears cpu_reset_req; 'W' ADDR LEN DATA*(LEN*DATA_BYTES); 'R' ADDR LEN.
REQ-021 LEN is one byte giving the word count; legal range 1..MAX_BURST.
REQ-022 States: IDLE, GET_ADDR, GET_LEN, GET_DATA, MEM_WR, MEM_RD, SEND_DATA, SEND_RESP.
REQ-023 IDLE + rx_valid: 'P', 'H' and 'G' go to SEND_RESP with 'A'; 'W' and 'R' go to GET_ADDR; any other byte goes to SEND_RESP with 'N' (0x4E).
REQ-024 GET_ADDR shifts in ADDR_BYTES bytes, then goes to GET_LEN.
REQ-025 GET_LEN: LEN of 0 or LEN > MAX_BURST goes to SEND_RESP 'N' and the command is discarded; otherwise 'W' goes to GET_DATA and 'R' goes to MEM_RD.
REQ-026 GET_DATA shifts in DATA_BYTES bytes, then goes to MEM_WR.
REQ-027 MEM_WR: mem_req=1, mem_we=1 until mem_ack; on ack, address += DATA_BYTES and remaining word count decrements; go to GET_DATA if words remain, else SEND_RESP 'A'.
REQ-028 MEM_RD: mem_req=1, mem_we=0 until mem_ack; capture mem_rdata on ack and go to SEND_DATA.
REQ-029 SEND_DATA sends DATA_BYTES bytes MSB first; on the last byte, address increments and the count decrements; go to MEM_RD if words remain, else IDLE (no trailing 'A').
REQ-030 tx_start is issued only in a cycle with tx_busy=0, is never asserted in two consecutive cycles, and tx_byte is stable while tx_start=1.
REQ-031 SEND_RESP issues exactly one byte, then returns to IDLE.
REQ-032 mem_req is never asserted outside MEM_WR/MEM_RD; mem_addr/mem_wdata/mem_we are stable while mem_req=1.
REQ-033 Address arithmetic wraps modulo 2^AW.
REQ-034 In GET_ADDR, GET_LEN and GET_DATA, a cycle counter resets on every rx_valid; reaching TIMEOUT cycles goes to SEND_RESP 'N' and aborts the command; words already written stay written.
REQ-035 rx_valid is ignored in MEM_*, SEND_DATA and SEND_RESP, and the byte is dropped.
REQ-036 Every 'N' increments err_count, saturating at 255.
REQ-037 There is no memory-side timeout; the block waits indefinitely for mem_ack.

Reset
REQ-038 RST=1 forces state IDLE; tx_start, mem_req, mem_we and cpu_reset_req become 0; err_count, counters and address/data registers become 0.
REQ-039 RST mid-command abandons it immediately: mem_req drops and no further tx_start is issued; the next command is parsed fresh.

Verification
REQ-040 'P' -> exactly one tx_start with tx_byte 0x41.
REQ-041 'H' then 'G' -> cpu_reset_req rises after 'H' and falls after 'G'; each command returns 0x41.
REQ-042 'W' 00000010 02 11223344 55667788, mem_ack delayed 3 cycles -> writes 0x11223344@0x10 and 0x55667788@0x14, then 0x41.
REQ-043 'R' FFFFFFFC 02 with mem returning A1B2C3D4, E5F60718 -> reads at 0xFFFFFFFC and 0x00000000 (wrap); TX bytes A1 B2 C3 D4 E5 F6 07 18.
REQ-044 'R' with LEN 00, LEN MAX_BURST+1, and 'X' -> each returns 0x4E with no mem_req; err_count = 3.
REQ-045 'W' then 2 address bytes then silence for TIMEOUT cycles -> 0x4E, no write, and a following 'P' is answered 0x41.
